seq_pattern_tx: RTL and testbench

- Serial pattern transmitter; the generator counterpart of the team's serial sequence detectors.
- Accepts a parallel pattern word with a repeat count and inter-repetition gap, then shifts it out MSB-first, one bit per clock.
- outbit connects directly to a detector's inbit in benches and in the self-test path.
- Output is fully registered, with a ready/start handshake and a done pulse per burst.

---
 rtl/seq_pattern_tx.sv | 184 ++++++++++++++++++
 tb/tb_seq_pattern_tx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial pattern transmitter.
// A parallel pattern word is latched on start and shifted out MSB-first,
// one bit per clock. The pattern is repeated rep_in+1 times, and gap_in idle
// bits are inserted between copies. A single-cycle done pulse follows the
// last bit of each burst. All outputs come directly from flops.
// Optional feature: define SEQ_TX_PARITY_EN to append one even-parity bit
// (the XOR of the pattern) after every copy.
module seq_pattern_tx #(
    parameter int   WIDTH    = 4,
    parameter int   CNT_W    = 4,
    parameter int   GAP_W    = 4,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pat_in,
    input  logic [CNT_W-1:0] rep_in,
    input  logic [GAP_W-1:0] gap_in,
    output logic             ready,
    output logic             busy,
    output logic             outbit,
    output logic             out_valid,
    output logic             done
);

    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BIT_W-1:0] MSB_IDX = BIT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
`ifdef SEQ_TX_PARITY_EN
        PARITY = 2'd3,
`endif
        GAP    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pat_q, pat_d;
    logic [CNT_W-1:0]   rep_cnt_q, rep_cnt_d;
    logic [GAP_W-1:0]   gap_len_q, gap_len_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               outbit_q, outbit_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               copy_end;
    logic               next_copy;

    // Next-state and next-output logic; copy_end and next_copy share the
    // end-of-copy and copy-restart decisions between the states that need them.
    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        rep_cnt_d   = rep_cnt_q;
        gap_len_d   = gap_len_q;
        gap_cnt_d   = gap_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        outbit_d    = outbit_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        copy_end    = 1'b0;
        next_copy   = 1'b0;

        case (state_q)
            IDLE: begin
                outbit_d    = IDLE_BIT;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                if (start) begin
                    pat_d       = pat_in;
                    rep_cnt_d   = rep_in;
                    gap_len_d   = gap_in;
                    gap_cnt_d   = '0;
                    bit_cnt_d   = MSB_IDX;
                    outbit_d    = pat_in[WIDTH-1];
                    out_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = SHIFT;
                end
            end

            SHIFT: begin
                if (bit_cnt_q != '0) begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                    outbit_d  = pat_q[bit_cnt_q - 1'b1];
                end else begin
`ifdef SEQ_TX_PARITY_EN
                    state_d     = PARITY;
                    outbit_d    = ^pat_q;
                    out_valid_d = 1'b1;
`else
                    copy_end = 1'b1;
`endif
                end
            end

`ifdef SEQ_TX_PARITY_EN
            PARITY: begin
                copy_end = 1'b1;
            end
`endif

            GAP: begin
                if (gap_cnt_q == '0) begin
                    next_copy = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end

            default: begin
                state_d     = IDLE;
                outbit_d    = IDLE_BIT;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase

        if (copy_end) begin
            if (rep_cnt_q != '0) begin
                rep_cnt_d = rep_cnt_q - 1'b1;
                if (gap_len_q != '0) begin
                    state_d     = GAP;
                    gap_cnt_d   = gap_len_q - 1'b1;
                    outbit_d    = IDLE_BIT;
                    out_valid_d = 1'b0;
                end else begin
                    next_copy = 1'b1;
                end
            end else begin
                state_d     = IDLE;
                outbit_d    = IDLE_BIT;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                done_d      = 1'b1;
            end
        end

        if (next_copy) begin
            state_d     = SHIFT;
            bit_cnt_d   = MSB_IDX;
            outbit_d    = pat_q[WIDTH-1];
            out_valid_d = 1'b1;
        end
    end

    // State, counters, shadow registers and outputs; reset forces idle values at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pat_q       <= '0;
            rep_cnt_q   <= '0;
            gap_len_q   <= '0;
            gap_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            outbit_q    <= IDLE_BIT;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            rep_cnt_q   <= rep_cnt_d;
            gap_len_q   <= gap_len_d;
            gap_cnt_q   <= gap_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            outbit_q    <= outbit_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign ready     = ~busy_q;
    assign busy      = busy_q;
    assign outbit    = outbit_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: self-checking bench for seq_pattern_tx.
// Expected serial streams are written as strings: '1'/'0' are valid bits and
// '-' marks an idle gap bit. Each burst ends with one done cycle.
module tb_seq_pattern_tx;

    localparam int NV = 8;

    logic       clk = 1'b0;
    logic       clk_run = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [3:0] pat_in = 4'd0;
    logic [3:0] rep_in = 4'd0;
    logic [3:0] gap_in = 4'd0;
    logic       ready;
    logic       busy;
    logic       outbit;
    logic       out_valid;
    logic       done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic ob;
        logic ov;
        logic dn;
        logic bsy;
    } exp_t;

    typedef struct {
        logic [3:0]   pat;
        logic [3:0]   rep;
        logic [3:0]   gap;
        logic [127:0] bits;
        logic [127:0] vld;
        int           len;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[NV];

    seq_pattern_tx #(
        .WIDTH(4),
        .CNT_W(4),
        .GAP_W(4),
        .IDLE_BIT(1'b0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .pat_in(pat_in),
        .rep_in(rep_in),
        .gap_in(gap_in),
        .ready(ready),
        .busy(busy),
        .outbit(outbit),
        .out_valid(out_valid),
        .done(done)
    );

    // Free-running clock, held low until the reset-only check is done
    always #5 if (clk_run) clk = ~clk;

    // Hard time limit so the bench always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    function automatic string repStr(string u, int n);
        string r;
        r = "";
        for (int i = 0; i < n; i++) r = {r, u};
        return r;
    endfunction

    function automatic vec_t mkVec(logic [3:0] pat, logic [3:0] rep, logic [3:0] gap, string s);
        vec_t v;
        v.pat  = pat;
        v.rep  = rep;
        v.gap  = gap;
        v.bits = '0;
        v.vld  = '0;
        v.len  = s.len();
        for (int i = 0; i < s.len(); i++) begin
            v.bits[i] = (s[i] == "1");
            v.vld[i]  = (s[i] != "-");
        end
        return v;
    endfunction

    task automatic checkOutput(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic checkCycle(string tag, exp_t e);
        checkOutput({tag, " outbit"}, outbit, e.ob);
        checkOutput({tag, " out_valid"}, out_valid, e.ov);
        checkOutput({tag, " done"}, done, e.dn);
        checkOutput({tag, " busy"}, busy, e.bsy);
        checkOutput({tag, " ready"}, ready, ~e.bsy);
    endtask

    task automatic pushExpected(vec_t v);
        exp_t e;
        for (int i = 0; i < v.len; i++) begin
            e.ob  = v.bits[i];
            e.ov  = v.vld[i];
            e.dn  = 1'b0;
            e.bsy = 1'b1;
            sb.push_back(e);
        end
        e.ob  = 1'b0;
        e.ov  = 1'b0;
        e.dn  = 1'b1;
        e.bsy = 1'b0;
        sb.push_back(e);
    endtask

    // Drive a one-cycle start request and queue the expected burst
    task automatic applyStimulus(vec_t v);
        pat_in = v.pat;
        rep_in = v.rep;
        gap_in = v.gap;
        start  = 1'b1;
        pushExpected(v);
    endtask

    // Pop and compare one expectation per cycle, scrambling inputs after acceptance
    task automatic drainScoreboard(string tag);
        exp_t e;
        int   c;
        c = 0;
        while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            checkCycle($sformatf("%s c%0d", tag, c), e);
            start  = 1'b0;
            pat_in = 4'($urandom_range(0, 15));
            rep_in = 4'($urandom_range(0, 15));
            gap_in = 4'($urandom_range(0, 15));
            c++;
        end
    endtask

    initial begin
        vec_t v1;
        vec_t v2;
        exp_t e;
        int   c;
        int   l1;

        // Reset with the clock stopped: outputs must go idle with no edge
        #1 reset = 1'b1;
        #1;
        checkOutput("async reset outbit", outbit, 1'b0);
        checkOutput("async reset out_valid", out_valid, 1'b0);
        checkOutput("async reset ready", ready, 1'b1);
        checkOutput("async reset busy", busy, 1'b0);
        checkOutput("async reset done", done, 1'b0);
        clk_run = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

`ifdef SEQ_TX_PARITY_EN
        vecs[0] = mkVec(4'b1001, 4'd0,  4'd0,  "10010");
        vecs[1] = mkVec(4'b1011, 4'd2,  4'd2,  "10111--10111--10111");
        vecs[2] = mkVec(4'b1011, 4'd1,  4'd1,  "10111-10111");
        vecs[3] = mkVec(4'b0110, 4'd1,  4'd0,  "0110001100");
        vecs[4] = mkVec(4'b1111, 4'd0,  4'd3,  "11110");
        vecs[5] = mkVec(4'b0001, 4'd3,  4'd1,  "00011-00011-00011-00011");
        vecs[6] = mkVec(4'b1010, 4'd15, 4'd0,  repStr("10100", 16));
        vecs[7] = mkVec(4'b0100, 4'd1,  4'd15, {"01001", repStr("-", 15), "01001"});
`else
        vecs[0] = mkVec(4'b1001, 4'd0,  4'd0,  "1001");
        vecs[1] = mkVec(4'b1011, 4'd2,  4'd2,  "1011--1011--1011");
        vecs[2] = mkVec(4'b1011, 4'd1,  4'd1,  "1011-1011");
        vecs[3] = mkVec(4'b0110, 4'd1,  4'd0,  "01100110");
        vecs[4] = mkVec(4'b1111, 4'd0,  4'd3,  "1111");
        vecs[5] = mkVec(4'b0001, 4'd3,  4'd1,  "0001-0001-0001-0001");
        vecs[6] = mkVec(4'b1010, 4'd15, 4'd0,  repStr("1010", 16));
        vecs[7] = mkVec(4'b0100, 4'd1,  4'd15, {"0100", repStr("-", 15), "0100"});
`endif

        // Table vectors, each started in the done cycle of the previous burst
        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i]);
            drainScoreboard($sformatf("vec%0d", i));
        end

        // start held high; pat_in changes mid-burst and only the next burst sees it
`ifdef SEQ_TX_PARITY_EN
        v1 = mkVec(4'b1001, 4'd0, 4'd0, "10010");
        v2 = mkVec(4'b0110, 4'd0, 4'd0, "01100");
`else
        v1 = mkVec(4'b1001, 4'd0, 4'd0, "1001");
        v2 = mkVec(4'b0110, 4'd0, 4'd0, "0110");
`endif
        l1 = v1.len;
        @(negedge clk);
        applyStimulus(v1);
        pushExpected(v2);
        c = 0;
        while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            checkCycle($sformatf("held c%0d", c), e);
            if (c == 1) pat_in = 4'b0110;
            if (c == l1 + 1) start = 1'b0;
            c++;
        end

        // Reset two bits into a burst: idle at once, no done, then a clean restart
        @(negedge clk);
        pat_in = 4'b1001;
        rep_in = 4'd0;
        gap_in = 4'd0;
        start  = 1'b1;
        @(negedge clk);
        checkOutput("midreset bit0 outbit", outbit, 1'b1);
        checkOutput("midreset bit0 out_valid", out_valid, 1'b1);
        start = 1'b0;
        @(negedge clk);
        checkOutput("midreset bit1 outbit", outbit, 1'b0);
        checkOutput("midreset bit1 out_valid", out_valid, 1'b1);
        reset = 1'b1;
        #1;
        checkOutput("midreset outbit", outbit, 1'b0);
        checkOutput("midreset out_valid", out_valid, 1'b0);
        checkOutput("midreset busy", busy, 1'b0);
        checkOutput("midreset ready", ready, 1'b1);
        checkOutput("midreset done", done, 1'b0);
        #2 reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput($sformatf("post reset done c%0d", k), done, 1'b0);
            checkOutput($sformatf("post reset out_valid c%0d", k), out_valid, 1'b0);
        end
        applyStimulus(v1);
        drainScoreboard("after reset");

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
